// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: Moore sequencer, ALU decode,
// NZCV flag register, condition evaluation and architectural write gating.
module multicycle_control (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   output logic [1:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
   logic       condex_q, condex_d;

   logic [3:0] cmd;
   logic       is_cmp;
   logic       s_eff;
   logic [1:0] flagw;
   logic [1:0] dp_ctl;
   logic       dp_nowrite;
   logic       nowrite;
   logic       cond_ok;
   logic       alu_op, regw, memw, branch, fetch;
   logic       n_f, z_f, c_f, v_f;

   assign cmd    = Funct[4:1];
   assign is_cmp = (cmd == 4'b1010);
   // CMP always sets flags, whatever its S bit says
   assign s_eff  = Funct[0] | is_cmp;
   assign flagw[1] = s_eff;
   assign flagw[0] = s_eff & ((cmd == 4'b0100) | (cmd == 4'b0010) | is_cmp);

   // Data-processing command decode; CMP and unsupported commands suppress writeback
   always_comb begin
      dp_ctl     = 2'b00;
      dp_nowrite = 1'b0;
      case (cmd)
         4'b0100: dp_ctl = 2'b00;
         4'b0010: dp_ctl = 2'b01;
         4'b0000: dp_ctl = 2'b10;
         4'b1100: dp_ctl = 2'b11;
         4'b1010: begin dp_ctl = 2'b01; dp_nowrite = 1'b1; end
         default: begin dp_ctl = 2'b00; dp_nowrite = 1'b1; end
      endcase
   end

   // Memory instructions reuse Funct[4:1] for addressing bits, so only
   // data-processing instructions may suppress a register write
   assign nowrite = (Op == 2'b00) & dp_nowrite;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Condition field evaluated against the current architectural flags
   always_comb begin
      cond_ok = 1'b0;
      case (Cond)
         4'b0000: cond_ok = z_f;
         4'b0001: cond_ok = ~z_f;
         4'b0010: cond_ok = c_f;
         4'b0011: cond_ok = ~c_f;
         4'b0100: cond_ok = n_f;
         4'b0101: cond_ok = ~n_f;
         4'b0110: cond_ok = v_f;
         4'b0111: cond_ok = ~v_f;
         4'b1000: cond_ok = c_f & ~z_f;
         4'b1001: cond_ok = ~c_f | z_f;
         4'b1010: cond_ok = (n_f == v_f);
         4'b1011: cond_ok = (n_f != v_f);
         4'b1100: cond_ok = ~z_f & (n_f == v_f);
         4'b1101: cond_ok = z_f | (n_f != v_f);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Next-state sequencing
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // CondExReg captures the pre-execute verdict at the end of DECODE; flags
   // load at the end of EXECUTE, with NZ and CV enabled separately
   always_comb begin
      condex_d = (state_q == S_DECODE) ? cond_ok : condex_q;
      flags_d  = flags_q;
      if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && condex_q) begin
         if (flagw[1]) flags_d[3:2] = ALUFlags[3:2];
         if (flagw[0]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   // State, flag and condition registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         condex_q <= condex_d;
      end
   end

   // Per-state Moore controls; unlisted controls stay 0
   always_comb begin
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      AdrSrc    = 1'b0;
      alu_op    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      branch    = 1'b0;
      fetch     = 1'b0;
      case (state_q)
         S_FETCH: begin
            fetch = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_MEMADR:   ALUSrcB = 2'b01;
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
         S_MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin ALUSrcB = 2'b01; alu_op = 1'b1; end
         S_ALUWB:    regw = 1'b1;
         S_BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
         end
         default: ;
      endcase
   end

   // Gated architectural writes; reset holds every enable low immediately
   always_comb begin
      ALUControl = alu_op ? dp_ctl : 2'b00;
      ImmSrc     = Op;
      RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
      IRWrite    = reset_n & fetch;
      RegWrite   = reset_n & regw & condex_q & ~nowrite;
      MemWrite   = reset_n & memw & condex_q;
      PCWrite    = reset_n & (fetch |
                   (condex_q & (branch | (regw & ~nowrite & (Rd == 4'hF)))));
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors,
// flag register contents, condition gating and reset abort.
module tb_multicycle_control;

   logic       clk, reset_n;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd, Cond, ALUFlags;
   logic [1:0] ALUControl, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
   logic       ALUSrcA, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
   logic [11:0] obs;
   int checks = 0;
   int errors = 0;

   multicycle_control dut (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd),
      .Cond(Cond), .ALUFlags(ALUFlags), .ALUControl(ALUControl),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .AdrSrc(AdrSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRW, PCW, RegW, MemW}
   assign obs = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                 IRWrite, PCWrite, RegWrite, MemWrite};

   function automatic logic [11:0] cw(input logic [1:0] ac, input logic sa,
         input logic [1:0] sb, input logic [1:0] rs, input logic adr,
         input logic [3:0] en);
      return {ac, sa, sb, rs, adr, en};
   endfunction

   localparam logic [11:0] V_FETCH = {2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 4'b1100};
   localparam logic [11:0] V_RST   = {2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 4'b0000};
   localparam logic [11:0] V_DEC   = {2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 4'b0000};

   task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
         input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] af);
      Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlags = af;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_instr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b0000);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs !== V_RST) begin
         errors++; $display("FAIL reset_vec got %b want %b", obs, V_RST);
      end
      checks++;
      if (dut.flags_q !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", dut.flags_q);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_add();
      logic [11:0] exp [4];
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010)};
      set_instr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL add_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (dut.flags_q !== 4'b0000) begin
         errors++; $display("FAIL add_flags got %b want 0000", dut.flags_q);
      end
   endtask

   task automatic test_cond();
      logic [11:0] exp [4];
      // SUBS R1, Z from ALU
      exp = '{V_FETCH, V_DEC, cw(2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010)};
      set_instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0100);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL subs_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (dut.flags_q !== 4'b0100) begin
         errors++; $display("FAIL subs_flags got %b want 0100", dut.flags_q);
      end
      // ADDEQ: taken
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010)};
      set_instr(2'b00, 6'b001000, 4'd2, 4'b0000, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL addeq_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      // ADDNE: not taken, still walks all states
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000)};
      set_instr(2'b00, 6'b001000, 4'd2, 4'b0001, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL addne_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (dut.flags_q !== 4'b0100) begin
         errors++; $display("FAIL addne_flags got %b want 0100", dut.flags_q);
      end
   endtask

   task automatic test_cmp();
      logic [11:0] exp [4];
      exp = '{V_FETCH, V_DEC, cw(2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000)};
      set_instr(2'b00, 6'b010100, 4'd3, 4'b1110, 4'b1001);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL cmp_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (dut.flags_q !== 4'b1001) begin
         errors++; $display("FAIL cmp_flags got %b want 1001", dut.flags_q);
      end
   endtask

   task automatic test_mem();
      logic [11:0] ld [5];
      logic [11:0] st [4];
      ld = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 4'b0000),
             cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0000),
             cw(2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 4'b0010)};
      set_instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
      #1; checks++;
      if ({ImmSrc, RegSrc} !== 4'b0110) begin
         errors++; $display("FAIL ldr_src got %b want 0110", {ImmSrc, RegSrc});
      end
      for (int i = 0; i < 5; i++) begin
         #1; checks++;
         if (obs !== ld[i]) begin
            errors++; $display("FAIL ldr_cyc%0d got %b want %b", i, obs, ld[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      st = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 4'b0000),
             cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 4'b0001)};
      set_instr(2'b01, 6'b011000, 4'd2, 4'b1110, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== st[i]) begin
            errors++; $display("FAIL str_cyc%0d got %b want %b", i, obs, st[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [11:0] exp [3];
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b01, 2'b10, 1'b0, 4'b0100)};
      set_instr(2'b10, 6'b100000, 4'd0, 4'b1110, 4'b0000);
      #1; checks++;
      if ({ImmSrc, RegSrc} !== 4'b1001) begin
         errors++; $display("FAIL b_src got %b want 1001", {ImmSrc, RegSrc});
      end
      for (int i = 0; i < 3; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL b_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b01, 2'b10, 1'b0, 4'b0000)};
      set_instr(2'b10, 6'b100000, 4'd0, 4'b1111, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL bnv_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_undef_and_pc();
      logic [11:0] u [2];
      logic [11:0] exp [4];
      u = '{V_FETCH, V_DEC};
      set_instr(2'b11, 6'b000000, 4'd1, 4'b1110, 4'b0000);
      for (int i = 0; i < 2; i++) begin
         #1; checks++;
         if (obs !== u[i]) begin
            errors++; $display("FAIL undef_cyc%0d got %b want %b", i, obs, u[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      // ADD R15, immediate: writeback also writes the PC
      exp = '{V_FETCH, V_DEC, cw(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0110)};
      set_instr(2'b00, 6'b101000, 4'hF, 4'b1110, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL addpc_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset_abort();
      logic [11:0] exp [3];
      exp = '{V_FETCH, V_DEC, cw(2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000)};
      set_instr(2'b00, 6'b000001, 4'd1, 4'b1110, 4'b1010);
      for (int i = 0; i < 3; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL ands_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         if (i < 2) begin @(posedge clk); @(negedge clk); end
      end
      #2 reset_n = 1'b0;
      #1; checks++;
      if (obs !== V_RST) begin
         errors++; $display("FAIL abort_vec got %b want %b", obs, V_RST);
      end
      checks++;
      if (dut.flags_q !== 4'b0000) begin
         errors++; $display("FAIL abort_flags got %b want 0000", dut.flags_q);
      end
      @(posedge clk); @(negedge clk);
      #1; checks++;
      if ({dut.flags_q, obs} !== {4'b0000, V_RST}) begin
         errors++; $display("FAIL abort_hold got %b want %b", {dut.flags_q, obs}, {4'b0000, V_RST});
      end
      reset_n = 1'b1;
      #1; checks++;
      if (obs !== V_FETCH) begin
         errors++; $display("FAIL resume_fetch got %b want %b", obs, V_FETCH);
      end
      @(posedge clk); @(negedge clk);
      exp = '{V_DEC, cw(2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000),
              cw(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0010)};
      for (int i = 0; i < 3; i++) begin
         #1; checks++;
         if (obs !== exp[i]) begin
            errors++; $display("FAIL rerun_cyc%0d got %b want %b", i, obs, exp[i]);
         end
         @(posedge clk); @(negedge clk);
      end
      // ANDS loads NZ only; CV keeps its reset value
      checks++;
      if (dut.flags_q !== 4'b1000) begin
         errors++; $display("FAIL ands_flags got %b want 1000", dut.flags_q);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      set_instr(2'b00, 6'b000000, 4'd0, 4'b1110, 4'b0000);
      test_reset();
      test_add();
      test_cond();
      test_cmp();
      test_mem();
      test_branch();
      test_undef_and_pc();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
